// File: rtl/sys_deserialise_if.sv
// Row-collector bus: serial element input side and parallel row output side.
// master drives the serial stream, slave is the deserialiser.
interface sys_deserialise_if #(
  parameter int BitSize     = 8,
  parameter int NumOfNerves = 4,
  parameter int DepthOut    = 2
);
  localparam int RowW = $clog2(DepthOut + 1);

  logic                                in_valid;
  logic                                in_start;
  logic [BitSize-1:0]                  in_data;
  logic                                out_valid;
  logic                                out_start;
  logic                                out_last;
  logic [RowW-1:0]                     out_row;
  logic [NumOfNerves-1:0][BitSize-1:0] out_data;
  logic                                err_frame;

  modport master (
    output in_valid, in_start, in_data,
    input  out_valid, out_start, out_last, out_row, out_data, err_frame
  );

  modport slave (
    input  in_valid, in_start, in_data,
    output out_valid, out_start, out_last, out_row, out_data, err_frame
  );
endinterface

// File: rtl/sys_deserialise.sv
// Serial-to-parallel row collector: packs NumOfNerves elements (first element to the
// highest index) into one row. Optional SYS_DESER_ZERO_PAD_EN flushes partial rows zero-filled.
module sys_deserialise #(
  parameter int BitSize     = 8,
  parameter int NumOfNerves = 4,
  parameter int DepthOut    = 2
) (
  input logic               clk,
  input logic               res,
  sys_deserialise_if.slave  bus
);
  localparam int CW = $clog2(NumOfNerves + 1);
  localparam int IW = $clog2(NumOfNerves);
  localparam int RW = $clog2(DepthOut + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NumOfNerves - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(DepthOut - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, FILL = 1'b1} state_t;
  typedef logic [NumOfNerves-1:0][BitSize-1:0] row_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [IW-1:0]   idx_s;
  row_t            buf_r, buf_s, emit_data_s;
  logic            emit_s, err_s;
  logic [RW-1:0]   row_r;
  logic            out_valid_r, out_start_r, out_last_r, err_frame_r;
  logic [RW-1:0]   out_row_r;
  row_t            out_data_r;

  // Next-state, assembly-buffer and emission decode
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    buf_s       = buf_r;
    emit_s      = 1'b0;
    err_s       = 1'b0;
    emit_data_s = buf_r;
    idx_s       = IW'(NumOfNerves - 1) - IW'(cnt_r);
    case (state_r)
      IDLE: begin
        if (bus.in_valid && bus.in_start) begin
          buf_s                  = '0;
          buf_s[NumOfNerves-1]   = bus.in_data;
          cnt_s                  = CW'(1);
          state_s                = FILL;
        end else if (bus.in_valid) begin
          err_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        if (bus.in_valid && bus.in_start) begin
          // Restart: buffer is cleared so an unfinished row is already zero-padded
          err_s = 1'b1;
`ifdef SYS_DESER_ZERO_PAD_EN
          emit_s = 1'b1;
`else
          emit_s = 1'b0;
`endif
          buf_s                = '0;
          buf_s[NumOfNerves-1] = bus.in_data;
          cnt_s                = CW'(1);
        end else if (bus.in_valid) begin
          buf_s[idx_s] = bus.in_data;
          if (cnt_r == LAST_CNT) begin
            emit_s      = 1'b1;
            emit_data_s = buf_s;
            cnt_s       = '0;
            state_s     = IDLE;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end else begin
          state_s = FILL;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // Collection state: FSM, element counter and assembly buffer
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      buf_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      buf_r   <= buf_s;
    end
  end

  // Registered row output and group row counter
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      out_valid_r <= 1'b0;
      out_start_r <= 1'b0;
      out_last_r  <= 1'b0;
      err_frame_r <= 1'b0;
      out_row_r   <= '0;
      out_data_r  <= '0;
      row_r       <= '0;
    end else begin
      out_valid_r <= emit_s;
      out_start_r <= emit_s;
      out_last_r  <= emit_s && (row_r == LAST_ROW);
      err_frame_r <= err_s;
      if (emit_s) begin
        out_data_r <= emit_data_s;
        out_row_r  <= row_r;
        row_r      <= (row_r == LAST_ROW) ? '0 : row_r + RW'(1);
      end else begin
        out_data_r <= out_data_r;
        out_row_r  <= out_row_r;
        row_r      <= row_r;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_start = out_start_r;
  assign bus.out_last  = out_last_r;
  assign bus.err_frame = err_frame_r;
  assign bus.out_row   = out_row_r;
  assign bus.out_data  = out_data_r;
endmodule
